temac1_top: RTL and testbench

Simplified Ethernet register-access endpoint for the webcam FPGA. It receives command frames on the GMII receive port and applies write commands to an internal 16x8 register file. It answers read commands with a reply frame on the GMII transmit port. All logic runs on the single clock clk100. The GMII/MII clock outputs are generated internally as clk100/4 (25 MHz).

---
 rtl/temac1_pkg.sv | 24 ++
 rtl/temac1_rx_parser.sv | 66 ++++++
 rtl/temac1_top.sv | 116 +++++++++++
 tb/tb_temac1_top.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/temac1_pkg.sv
// temac1_pkg: shared constants, FSM state types and reply-frame byte generator
// for the register-access Ethernet endpoint.
package temac1_pkg;
  localparam logic [7:0] OP_WR = 8'hFF;
  localparam logic [7:0] OP_RD = 8'h00;
  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD = 8'hD5;
  localparam logic [4:0] IDX_OP = 5'd16;
  localparam logic [4:0] IDX_ADDR = 5'd17;
  localparam logic [4:0] IDX_DATA = 5'd18;
  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  // 8 preamble/SFD + 14 header + 46 payload bytes, no FCS
  localparam int FRAME_LEN = 68;
  typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA, RX_SKIP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_FRAME} tx_state_t;
  // Byte i of a read-reply frame; bytes past the data byte are zero pad.
  function automatic logic [7:0] frame_byte(input logic [6:0] i, input logic [47:0] dst,
                                            input logic [7:0] a, input logic [7:0] d);
    return i < 7 ? PREAMBLE : i == 7 ? SFD :
           i < 14 ? 8'(dst >> (8 * (13 - i))) :
           i < 20 ? 8'(LOCAL_MAC >> (8 * (19 - i))) :
           i == 21 ? 8'h02 : i == 22 ? a : i == 23 ? d : 8'h00;
  endfunction
endpackage

// File: rtl/temac1_rx_parser.sv
// temac1_rx_parser: receive FSM and command decode.
// Ports: clk/rst_n (async active-low), stb sample strobe, dv/rxd receive data;
// wr_en/rd_req one-cycle command pulses with cmd_addr, cmd_data, src_mac.
module temac1_rx_parser
  import temac1_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        dv,
  input  logic [7:0]  rxd,
  output logic        wr_en,
  output logic        rd_req,
  output logic [7:0]  cmd_addr,
  output logic [7:0]  cmd_data,
  output logic [47:0] src_mac
);
  rx_state_t st;
  logic [4:0] idx;
  logic       ph;
  logic [7:0] op;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= RX_IDLE;
      idx <= '0;
      ph <= 1'b0;
      op <= '0;
      wr_en <= 1'b0;
      rd_req <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
      src_mac <= '0;
    end else begin
      wr_en <= 1'b0;
      rd_req <= 1'b0;
      if (stb)
        case (st)
          RX_IDLE: if (dv && rxd == PREAMBLE) st <= RX_PRE;
          RX_PRE:
            if (!dv) st <= RX_IDLE;
            else if (rxd == SFD) begin
              st <= RX_DATA;
              idx <= '0;
              ph <= 1'b0;
            end
          RX_DATA:
            if (!dv) st <= RX_IDLE;
            else if (!ph) ph <= 1'b1;
            else begin
              // second sample of the pair: the byte is stable, capture it
              ph <= 1'b0;
              idx <= idx + 5'd1;
              if (idx >= 5'd6 && idx <= 5'd11) src_mac <= {src_mac[39:0], rxd};
              if (idx == IDX_OP) op <= rxd;
              if (idx == IDX_ADDR) cmd_addr <= rxd;
              if (idx == IDX_DATA) begin
                cmd_data <= rxd;
                wr_en <= op == OP_WR;
                rd_req <= op == OP_RD;
                st <= RX_SKIP;
              end
            end
          default: if (!dv) st <= RX_IDLE;
        endcase
    end
endmodule

// File: rtl/temac1_top.sv
// temac1_top: Ethernet register-access endpoint with a 16x8 register file.
// Ports: clk100 sole clock, reset async active-low; gmii_rxd2/gmii_rx_dv2 command
// input; gmii_txd/gmii_tx_en reply output; gmii_tx_clk/tx_clk/rx_clk = clk100/4;
// tx_ifg_delay extra gap, pause_req holds off new frames; phy_reset active-low.
module temac1_top
  import temac1_pkg::*;
#(
  parameter int PHY_RST_CYCLES = 1000,
  parameter int NUM_REGS = 16,
  parameter int MIN_IFG = 12
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        gtx_clk,
  input  logic        mii_tx_clk,
  input  logic        gmii_rx_clk,
  input  logic [7:0]  gmii_rxd2,
  input  logic        gmii_rx_dv2,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic        gmii_crs,
  input  logic        gmii_col,
  input  logic [7:0]  tx_ifg_delay,
  input  logic        pause_req,
  input  logic [15:0] pause_val,
  output logic        gmii_tx_clk,
  output logic        tx_clk,
  output logic        rx_clk,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        phy_reset
);
  localparam int PW = $clog2(PHY_RST_CYCLES + 1);
  localparam int AW = $clog2(NUM_REGS);
  logic [1:0] div;
  logic [PW-1:0] prst_cnt;
  logic [7:0] regs [NUM_REGS];
  logic wr_en, rd_req, pend, start;
  logic [7:0] cmd_addr, cmd_data, pend_addr, tx_addr;
  logic [47:0] src_mac, pend_mac, tx_mac;
  tx_state_t tx_state;
  logic [6:0] tx_cnt;
  logic tx_ph;
  logic [9:0] ifg;
  logic unused;
  assign unused = ^{gtx_clk, mii_tx_clk, gmii_rx_clk, gmii_rxd, gmii_rx_dv, gmii_rx_er,
                    gmii_crs, gmii_col, pause_val};
  assign gmii_tx_clk = div[1];
  assign tx_clk = div[1];
  assign rx_clk = div[1];
  assign gmii_tx_er = 1'b0;
  assign start = div == 2'd1 && tx_state == TX_IDLE && ifg == '0 && pend && !pause_req;
  temac1_rx_parser u_rx (
    .clk(clk100), .rst_n(reset), .stb(div == 2'd3), .dv(gmii_rx_dv2), .rxd(gmii_rxd2),
    .wr_en(wr_en), .rd_req(rd_req), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .src_mac(src_mac)
  );
  always_ff @(posedge clk100 or negedge reset)
    if (!reset) begin
      div <= '0;
      prst_cnt <= '0;
      phy_reset <= 1'b0;
      regs <= '{default: '0};
      pend <= 1'b0;
      pend_addr <= '0;
      pend_mac <= '0;
      tx_addr <= '0;
      tx_mac <= '0;
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_ph <= 1'b0;
      ifg <= '0;
      gmii_txd <= '0;
      gmii_tx_en <= 1'b0;
    end else begin
      div <= div + 2'd1;
      if (!phy_reset) begin
        prst_cnt <= prst_cnt + 1'b1;
        phy_reset <= prst_cnt == PW'(PHY_RST_CYCLES - 1);
      end
      if (wr_en) regs[cmd_addr[AW-1:0]] <= cmd_data;
      // a newer read replaces the one still waiting
      if (rd_req) begin
        pend_addr <= cmd_addr;
        pend_mac <= src_mac;
      end
      pend <= rd_req | (pend & !start);
      if (div == 2'd1)
        if (tx_state == TX_IDLE) begin
          if (ifg != '0) ifg <= ifg - 10'd1;
          else if (start) begin
            tx_state <= TX_FRAME;
            tx_cnt <= '0;
            tx_ph <= 1'b0;
            tx_addr <= pend_addr;
            tx_mac <= pend_mac;
            gmii_txd <= PREAMBLE;
            gmii_tx_en <= 1'b1;
          end
        end else if (!tx_ph) tx_ph <= 1'b1;
        else begin
          tx_ph <= 1'b0;
          if (tx_cnt == 7'(FRAME_LEN - 1)) begin
            tx_state <= TX_IDLE;
            gmii_tx_en <= 1'b0;
            gmii_txd <= '0;
            // counted in strobes: two per byte slot
            ifg <= 10'(2 * (MIN_IFG + int'(tx_ifg_delay)));
          end else begin
            tx_cnt <= tx_cnt + 7'd1;
            gmii_txd <= frame_byte(tx_cnt + 7'd1, tx_mac, tx_addr, regs[tx_addr[AW-1:0]]);
          end
        end
    end
endmodule

// File: tb/tb_temac1_top.sv
// tb_temac1_top: directed self-checking bench for temac1_top.
module tb_temac1_top;
  logic clk100 = 1'b0, reset = 1'b0;
  logic [7:0] gmii_rxd2 = '0, tx_ifg_delay = '0;
  logic gmii_rx_dv2 = 1'b0, pause_req = 1'b0;
  logic gmii_tx_clk, tx_clk, rx_clk, gmii_tx_en, gmii_tx_er, phy_reset;
  logic [7:0] gmii_txd;
  int checks = 0, failures = 0;
  logic [7:0] q[$];
  int run_len = 0, last_run = 0, low_run = 0, gap_min = 1000000;
  logic prev_en = 1'b0;

  always #5 clk100 = ~clk100;

  temac1_top dut (
    .clk100(clk100), .reset(reset), .gtx_clk(1'b0), .mii_tx_clk(1'b0), .gmii_rx_clk(gmii_tx_clk),
    .gmii_rxd2(gmii_rxd2), .gmii_rx_dv2(gmii_rx_dv2), .gmii_rxd(8'h00), .gmii_rx_dv(1'b0),
    .gmii_rx_er(1'b0), .gmii_crs(1'b0), .gmii_col(1'b0), .tx_ifg_delay(tx_ifg_delay),
    .pause_req(pause_req), .pause_val(16'h0000), .gmii_tx_clk(gmii_tx_clk), .tx_clk(tx_clk),
    .rx_clk(rx_clk), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .phy_reset(phy_reset)
  );

  always @(negedge gmii_tx_clk) begin
    if (gmii_tx_en) begin
      q.push_back(gmii_txd);
      if (!prev_en && low_run < gap_min) gap_min = low_run;
      run_len++;
      low_run = 0;
    end else begin
      if (prev_en) last_run = run_len;
      run_len = 0;
      low_run++;
    end
    prev_en = gmii_tx_en;
  end

  initial begin
    #500us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v, input logic dv);
    repeat (2) begin
      @(posedge gmii_tx_clk);
      #1;
      gmii_rxd2 = v;
      gmii_rx_dv2 = dv;
    end
  endtask

  task automatic send(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d, input int nbytes);
    logic [7:0] b [20];
    b = '{8'h0E, 8'hDA, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h5A, 8'h02, 8'h03,
          8'h04, 8'h05, 8'h06, 8'h00, 8'h2E, 8'hFF, 8'hFF, 8'hAA, 8'hDD, 8'h00};
    b[16] = op;
    b[17] = a;
    b[18] = d;
    for (int i = 0; i < 8; i++) drive(i < 7 ? 8'h55 : 8'hD5, 1'b1);
    for (int i = 0; i < nbytes; i++) drive(b[i], 1'b1);
    drive(8'h00, 1'b0);
    drive(8'h00, 1'b0);
  endtask

  task automatic check_reply(input string tag, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] hdr [22];
    logic [7:0] e;
    hdr = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
            8'h06, 8'h5A, 8'h02, 8'h03, 8'h04, 8'h05,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02};
    for (int i = 0; i < 600 && q.size() < 136; i++) @(negedge gmii_tx_clk);
    chk({tag, "_arrived"}, 64'(q.size() >= 136), 64'd1);
    if (q.size() < 136) return;
    repeat (2) @(negedge gmii_tx_clk);
    chk({tag, "_en_len"}, 64'(last_run), 64'd136);
    for (int i = 0; i < 68; i++) begin
      e = i < 22 ? hdr[i] : i == 22 ? a : i == 23 ? d : 8'h00;
      chk($sformatf("%s_b%0d", tag, i), {q[2*i], q[2*i+1]}, {e, e});
    end
    repeat (136) void'(q.pop_front());
  endtask

  initial begin
    int rises;
    logic prev, same;
    #100;
    chk("rst_tx_clk", {gmii_tx_clk, tx_clk, rx_clk}, 3'b000);
    chk("rst_tx_en", gmii_tx_en, 1'b0);
    chk("rst_txd", gmii_txd, 8'h00);
    chk("rst_tx_er", gmii_tx_er, 1'b0);
    chk("rst_phy", phy_reset, 1'b0);
    #100;
    reset = 1'b1;
    repeat (4) @(negedge clk100);
    rises = 0;
    same = 1'b1;
    prev = gmii_tx_clk;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk100);
      if (gmii_tx_clk && !prev) rises++;
      if (tx_clk !== gmii_tx_clk || rx_clk !== gmii_tx_clk) same = 1'b0;
      prev = gmii_tx_clk;
    end
    chk("clk_rises_80", 64'(rises), 64'd20);
    chk("clk_outs_equal", same, 1'b1);
    repeat (900) @(negedge clk100);
    chk("phy_low_990", phy_reset, 1'b0);
    repeat (20) @(negedge clk100);
    chk("phy_high_1010", phy_reset, 1'b1);
    chk("idle_tx_en", gmii_tx_en, 1'b0);

    send(8'hFF, 8'hAA, 8'hDD, 20);
    send(8'h42, 8'hAA, 8'h33, 20);
    repeat (50) @(negedge gmii_tx_clk);
    chk("write_no_tx", 64'(q.size()), 64'd0);

    send(8'h00, 8'hAA, 8'h00, 20);
    check_reply("read_aa", 8'hAA, 8'hDD);

    send(8'hFF, 8'h0A, 8'h11, 18);
    repeat (50) @(negedge gmii_tx_clk);
    chk("abort_no_tx", 64'(q.size()), 64'd0);
    send(8'h00, 8'hAA, 8'h00, 20);
    check_reply("after_abort", 8'hAA, 8'hDD);

    send(8'hFF, 8'h03, 8'h5C, 20);
    pause_req = 1'b1;
    send(8'h00, 8'h13, 8'h00, 20);
    repeat (150) @(negedge gmii_tx_clk);
    chk("paused_no_tx", 64'(q.size()), 64'd0);
    pause_req = 1'b0;
    check_reply("after_pause", 8'h13, 8'h5C);

    tx_ifg_delay = 8'd8;
    send(8'h00, 8'hAA, 8'h00, 20);
    gap_min = 1000000;
    send(8'h00, 8'h13, 8'h00, 20);
    check_reply("b2b_first", 8'hAA, 8'hDD);
    check_reply("b2b_second", 8'h13, 8'h5C);
    chk("b2b_gap_ge_40", 64'(gap_min >= 40 && gap_min < 60), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
